// File: rtl/gpio_in_filter_pkg.sv
// gpio_in_filter_pkg: shared widths, debounce constants and a clog2 helper for the GPIO input filter
package gpio_in_filter_pkg;

   localparam int GPIO_WIDTH         = 8;
   localparam int DEBOUNCE_CYCLES_SIM = 4;
   // about 170 us at the 6 MHz CPU clock
   localparam int DEBOUNCE_CYCLES_HW  = 1024;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // a single-cycle debounce still needs a one-bit counter
   function automatic int cnt_width(input int d);
      return (clog2(d) > 1) ? clog2(d) : 1;
   endfunction

endpackage

// File: rtl/gpio_in_filter_if.sv
// gpio_in_filter_if: pad, debounced level, edge and pin-change signals between the filter and its user
interface gpio_in_filter_if #(
   parameter int WIDTH = gpio_in_filter_pkg::GPIO_WIDTH
);
   logic [WIDTH-1:0] pad_in;
   logic [WIDTH-1:0] pin_out;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] pcmsk;
   logic             pcif;
   logic             pcif_clr;

   modport master (
      output pad_in, pcmsk, pcif_clr,
      input  pin_out, rise, fall, pcif
   );

   modport slave (
      input  pad_in, pcmsk, pcif_clr,
      output pin_out, rise, fall, pcif
   );
endinterface

// File: rtl/gpio_in_filter_debounce_bit.sv
// gpio_in_filter_debounce_bit: two-flop synchroniser, debounce counter, stable level and edge pulses for one pad
module gpio_in_filter_debounce_bit
   import gpio_in_filter_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
   parameter logic RESET_BIT       = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pad_i,
   output logic pin_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          pin_q, pin_d;
   logic          rise_q, fall_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          differ, accept;

   assign differ = sync2_q != pin_q;
   assign accept = differ && (cnt_q == LAST);

   // bring the asynchronous pad into the clk domain with nothing between the flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= RESET_BIT;
         sync2_q <= RESET_BIT;
      end else begin
         sync1_q <= pad_i;
         sync2_q <= sync1_q;
      end
   end

   // any agreement restarts the count, so the counter tops out at LAST and never wraps
   always_comb begin
      cnt_d = (!differ || accept) ? '0 : cnt_q + 1'b1;
      pin_d = accept ? sync2_q : pin_q;
   end

   // debounce state plus edge pulses aligned with the new stable level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         pin_q  <= RESET_BIT;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pin_q  <= pin_d;
         rise_q <= accept & sync2_q;
         fall_q <= accept & ~sync2_q;
      end
   end

   assign pin_o  = pin_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-bit synchronise and debounce of GPIO pads with edge pulses; GPIO_FILTER_PCINT_EN adds the sticky pin-change flag
module gpio_in_filter
   import gpio_in_filter_pkg::*;
#(
   parameter int               WIDTH           = GPIO_WIDTH,
   parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   gpio_in_filter_if.slave gpio
);

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      gpio_in_filter_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_BIT       (RESET_LEVEL[b])
      ) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .pad_i   (gpio.pad_in[b]),
         .pin_o   (gpio.pin_out[b]),
         .rise_o  (gpio.rise[b]),
         .fall_o  (gpio.fall[b])
      );
   end

`ifdef GPIO_FILTER_PCINT_EN
   logic pcif_q, pcif_d;

   // an unmasked edge sets the flag and beats a simultaneous clear
   always_comb
      pcif_d = (|((gpio.rise | gpio.fall) & gpio.pcmsk)) ? 1'b1 : gpio.pcif_clr ? 1'b0 : pcif_q;

   // sticky flag register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pcif_q <= 1'b0;
      else          pcif_q <= pcif_d;
   end

   assign gpio.pcif = pcif_q;
`else
   assign gpio.pcif = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: scoreboard bench comparing the filter against a sliding-window reference model
module tb_gpio_in_filter;
   import gpio_in_filter_pkg::*;

   localparam int           W   = GPIO_WIDTH;
   localparam int           D   = DEBOUNCE_CYCLES_SIM;
   localparam logic [W-1:0] RST = '0;

   typedef struct packed {
      logic [W-1:0] pin;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         pcif;
   } obs_t;

   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   gpio_in_filter_if #(.WIDTH(W)) gpio ();

   gpio_in_filter #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D),
      .RESET_LEVEL     (RST)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .gpio    (gpio)
   );

   always #5 clk = ~clk;

   // pad samples taken at each rising edge since reset release (index 0 = edge 1)
   logic [W-1:0] ph[$];
   obs_t         sbq[$];
   obs_t         m, nx, exp_o;
   int           k;

   // synchronised level seen by the filter just before edge e: the pad two edges earlier
   function automatic logic [W-1:0] s2_at(input int e);
      return (e >= 3) ? ph[e-3] : RST;
   endfunction

   // reference: a bit flips when its synchronised level has opposed the stable level for the last D post-reset edges
   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         ph.delete();
         sbq.delete();
         k = 0;
         m = '{pin: RST, rise: '0, fall: '0, pcif: 1'b0};
      end else begin
         ph.push_back(gpio.pad_in);
         k++;
         nx      = m;
         nx.rise = '0;
         nx.fall = '0;
         for (int b = 0; b < W; b++) begin
            logic         want, ok;
            logic [W-1:0] v;
            want = ~m.pin[b];
            ok   = 1'b1;
            for (int i = 0; i < D; i++) begin
               v = s2_at(k - i);
               if (k - i < 1 || v[b] != want) ok = 1'b0;
            end
            if (ok) begin
               nx.pin[b]  = want;
               nx.rise[b] = want;
               nx.fall[b] = ~want;
            end
         end
`ifdef GPIO_FILTER_PCINT_EN
         nx.pcif = (|((m.rise | m.fall) & gpio.pcmsk)) | (m.pcif & ~gpio.pcif_clr);
`else
         nx.pcif = 1'b0;
`endif
         m = nx;
         sbq.push_back(m);
      end
   end

   task automatic chk(input string n, input logic [W-1:0] got, input logic [W-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", n, got, want, $time);
      end
   endtask

   // monitor: outputs are presented every cycle, compared mid-cycle
   initial forever begin
      @(negedge clk);
      if (!reset_n || sbq.size() == 0) exp_o = '{pin: RST, rise: '0, fall: '0, pcif: 1'b0};
      else                             exp_o = sbq.pop_front();
      chk("pin_out", gpio.pin_out, exp_o.pin);
      chk("rise", gpio.rise, exp_o.rise);
      chk("fall", gpio.fall, exp_o.fall);
      chk("pcif", W'(gpio.pcif), W'(exp_o.pcif));
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      int idx;
      gpio.pad_in   = '1;
      gpio.pcmsk    = '0;
      gpio.pcif_clr = 1'b0;
      reset_n       = 1'b0;
      step(4);
      reset_n = 1'b1;
      step(10);
      gpio.pad_in = '0;
      step(10);
      gpio.pad_in[0] = 1'b1;
      step(3);
      gpio.pad_in[0] = 1'b0;
      step(8);
      gpio.pad_in[0] = 1'b1;
      step(10);
      gpio.pad_in[3] = 1'b1;
      step(10);
      gpio.pad_in[3] = 1'b0;
      step(10);
      gpio.pcmsk     = 8'h01;
      gpio.pad_in[1] = 1'b1;
      step(10);
      gpio.pad_in[0] = 1'b0;
      step(10);
      gpio.pcif_clr = 1'b1;
      step(1);
      gpio.pcif_clr = 1'b0;
      step(2);
      gpio.pad_in[0] = 1'b1;
      step(6);
      gpio.pcif_clr = 1'b1;
      step(1);
      gpio.pcif_clr = 1'b0;
      step(3);
      gpio.pcif_clr = 1'b1;
      step(1);
      gpio.pcif_clr = 1'b0;
      step(3);
      gpio.pad_in[2] = 1'b1;
      step(3);
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
      step(10);
      repeat (3000) begin
         if ($urandom_range(5) == 0) begin
            idx = int'($urandom_range(W - 1));
            gpio.pad_in[idx] = ~gpio.pad_in[idx];
         end
         if ($urandom_range(49) == 0) gpio.pcmsk = W'($urandom);
         gpio.pcif_clr = ($urandom_range(7) == 0);
         if ($urandom_range(499) == 0) begin
            reset_n = 1'b0;
            step(int'($urandom_range(3, 1)));
            reset_n = 1'b1;
         end
         step(1);
      end
      gpio.pcif_clr = 1'b0;
      step(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
